cpu: RTL and testbench

Five-stage in-order pipelined RV32 subset processor (IF, ID, EX, MEM, WB). It is the top level of the project and contains its own instruction memory, data memory and register file. Data hazards are resolved by forwarding, plus a one-cycle stall for load-use. Branches resolve in ID with static not-taken prediction and a one-slot flush.

---
 rtl/cpu_pkg.sv | 101 ++++++++++
 rtl/cpu_control.sv | 54 +++++
 rtl/cpu_dmem.sv | 18 +
 rtl/cpu_imem.sv | 19 +
 rtl/cpu_pc.sv | 19 +
 rtl/cpu_pipe_reg.sv | 29 ++
 rtl/cpu_regfile.sv | 32 +++
 rtl/cpu.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu.sv | 236 +++++++++++++++++++++++
 9 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the five-stage RV32 subset core.
// Inter-stage bundles, control word, ALU/forwarding codes.
package cpu_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRA = 3'b101;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef enum logic [1:0] {
      ALUOP_ADD = 2'b00,
      ALUOP_SUB = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_I   = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_XOR = 3'd3,
      ALU_SLL = 3'd4,
      ALU_MUL = 3'd5,
      ALU_SRA = 3'd6
   } alu_ctl_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_EXM = 2'b10
   } fwd_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
   } id_ex_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_to_reg;
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  rd;
   } ex_mem_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] mem_data;
      logic [31:0] alu_result;
      logic [4:0]  rd;
   } mem_wb_t;

   // EX/MEM wins over MEM/WB: it holds the younger producer.
   function automatic fwd_e fwd_sel(
      input logic [4:0] rs,
      input logic       exm_we,
      input logic [4:0] exm_rd,
      input logic       wb_we,
      input logic [4:0] wb_rd
   );
      if (exm_we && exm_rd != 5'd0 && exm_rd == rs) return FWD_EXM;
      if (wb_we && wb_rd != 5'd0 && wb_rd == rs) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/cpu_control.sv
// Main decoder. Unsupported encodings yield an all-zero control word.
// Branch_o flags a taken beq in ID.
module cpu_control import cpu_pkg::*; (
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       eq_i,
   output ctrl_t      ctrl_o,
   output logic       Branch_o
);

   logic r_ok;
   logic i_ok;

   always_comb begin
      ctrl_o   = '0;
      Branch_o = 1'b0;
      r_ok     = 1'b0;
      i_ok     = funct3_i == F3_ADD ||
                 (funct3_i == F3_SRA && funct7_i == F7_SUB);
      unique case (funct7_i)
         F7_BASE: r_ok = funct3_i inside {F3_ADD, F3_SLL, F3_XOR, F3_AND};
         F7_SUB, F7_MUL: r_ok = funct3_i == F3_ADD;
         default: r_ok = 1'b0;
      endcase
      unique case (opcode_i)
         OP_R: if (r_ok) begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALUOP_R;
         end
         OP_I: if (i_ok) begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_op    = ALUOP_I;
         end
         OP_LW: if (funct3_i == F3_W) begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.alu_src    = 1'b1;
         end
         OP_SW: if (funct3_i == F3_W) begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
         end
         OP_BEQ: if (funct3_i == F3_ADD) begin
            ctrl_o.alu_op = ALUOP_SUB;
            Branch_o      = eq_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_dmem.sv
// 32-word data memory: write on the clock edge, combinational read.
module cpu_dmem (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o
);

   logic [31:0] memory [0:31];

   always_ff @(posedge clk_i) begin
      if (we_i) memory[addr_i] <= wdata_i;
   end

   assign rdata_o = memory[addr_i];

endmodule

// File: rtl/cpu_imem.sv
// 256-word instruction memory, combinational read.
// The write port lets a loader fill it; the core ties it off.
module cpu_imem (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [7:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] instr_o
);

   logic [31:0] memory [0:255];

   always_ff @(posedge clk_i) begin
      if (we_i) memory[addr_i] <= wdata_i;
   end

   assign instr_o = memory[addr_i];

endmodule

// File: rtl/cpu_pc.sv
// Program counter register; loads pc_i when enabled.
module cpu_pc (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [31:0] pc_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_d;

   always_comb pc_d = en_i ? pc_i : pc_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pc_o <= '0;
      else       pc_o <= pc_d;
   end

endmodule

// File: rtl/cpu_pipe_reg.sv
// Generic pipeline register with hold (en_i low) and flush-to-zero.
// Flush only takes effect on an enabled cycle.
module cpu_pipe_reg #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         flush_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_d;
   logic [W-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (en_i) data_d = flush_i ? '0 : d_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) data_q <= '0;
      else       data_q <= data_d;
   end

   assign q_o = data_q;

endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file, x0 hardwired to zero.
// Same-cycle writes bypass to the read ports.
module cpu_regfile (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o
);

   logic [31:0] register [0:31];
   logic        wr;

   assign wr = we_i && rd_i != 5'd0;

   always_ff @(posedge clk_i) begin
      if (wr) register[rd_i] <= wdata_i;
   end

   always_comb begin
      rdata1_o = register[rs1_i];
      rdata2_o = register[rs2_i];
      if (wr && rd_i == rs1_i) rdata1_o = wdata_i;
      if (wr && rd_i == rs2_i) rdata2_o = wdata_i;
      if (rs1_i == 5'd0) rdata1_o = '0;
      if (rs2_i == 5'd0) rdata2_o = '0;
   end

endmodule

// File: rtl/cpu.sv
// Five-stage RV32 subset core: forwarding, load-use stall,
// branches resolved in ID with a one-slot flush.
module cpu import cpu_pkg::*; (
   input logic clk_i,
   input logic rst_i,
   input logic start_i
);

   if_id_t  ifid_d,  ifid_q;
   id_ex_t  idex_d,  idex_q;
   ex_mem_t exmem_d, exmem_q;
   mem_wb_t memwb_d, memwb_q;

   logic [31:0] pc, pc_next, instr, br_target;
   logic [31:0] rs1_data, rs2_data, imm;
   logic [31:0] alu_a, alu_b, fwd_b, alu_y;
   logic [31:0] mem_rdata, wb_data;
   logic [4:0]  id_rs1, id_rs2;
   logic        stall, branch, taken;
   ctrl_t       ctrl;
   alu_ctl_e    alu_ctl;
   fwd_e        fwd_a_sel, fwd_b_sel;

   // IF
   assign taken   = branch && !stall;
   assign pc_next = taken ? br_target : pc + 32'd4;

   cpu_pc PC (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (start_i && !stall),
      .pc_i  (pc_next),
      .pc_o  (pc)
   );

   cpu_imem Instruction_Memory (
      .clk_i   (clk_i),
      .we_i    (1'b0),
      .addr_i  (pc[9:2]),
      .wdata_i ('0),
      .instr_o (instr)
   );

   always_comb begin
      ifid_d.pc    = pc;
      ifid_d.instr = instr;
   end

   // A frozen PC must not re-issue the same word, so IF feeds bubbles.
   cpu_pipe_reg #(.W($bits(if_id_t))) IFID (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (!stall),
      .flush_i (taken || !start_i),
      .d_i     (ifid_d),
      .q_o     (ifid_q)
   );

   // ID
   assign id_rs1 = ifid_q.instr[19:15];
   assign id_rs2 = ifid_q.instr[24:20];

   cpu_regfile Registers (
      .clk_i    (clk_i),
      .we_i     (memwb_q.reg_write),
      .rd_i     (memwb_q.rd),
      .wdata_i  (wb_data),
      .rs1_i    (id_rs1),
      .rs2_i    (id_rs2),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   cpu_control Control (
      .opcode_i (ifid_q.instr[6:0]),
      .funct3_i (ifid_q.instr[14:12]),
      .funct7_i (ifid_q.instr[31:25]),
      .eq_i     (rs1_data == rs2_data),
      .ctrl_o   (ctrl),
      .Branch_o (branch)
   );

   always_comb begin
      unique case (ifid_q.instr[6:0])
         OP_SW: imm = {{20{ifid_q.instr[31]}},
                       ifid_q.instr[31:25], ifid_q.instr[11:7]};
         OP_BEQ: imm = {{20{ifid_q.instr[31]}}, ifid_q.instr[31],
                        ifid_q.instr[7], ifid_q.instr[30:25],
                        ifid_q.instr[11:8]};
         default: imm = {{20{ifid_q.instr[31]}}, ifid_q.instr[31:20]};
      endcase
   end

   assign br_target = ifid_q.pc + {imm[30:0], 1'b0};

   assign stall = idex_q.ctrl.mem_read && idex_q.rd != 5'd0 &&
                  (idex_q.rd == id_rs1 || idex_q.rd == id_rs2);

   always_comb begin
      idex_d.ctrl     = stall ? '0 : ctrl;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.imm      = imm;
      idex_d.rs1      = id_rs1;
      idex_d.rs2      = id_rs2;
      idex_d.rd       = ifid_q.instr[11:7];
      idex_d.funct3   = ifid_q.instr[14:12];
      idex_d.funct7   = ifid_q.instr[31:25];
   end

   cpu_pipe_reg #(.W($bits(id_ex_t))) IDEX (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (1'b1),
      .flush_i (1'b0),
      .d_i     (idex_d),
      .q_o     (idex_q)
   );

   // EX
   assign fwd_a_sel = fwd_sel(idex_q.rs1, exmem_q.reg_write, exmem_q.rd,
                              memwb_q.reg_write, memwb_q.rd);
   assign fwd_b_sel = fwd_sel(idex_q.rs2, exmem_q.reg_write, exmem_q.rd,
                              memwb_q.reg_write, memwb_q.rd);

   always_comb begin
      unique case (fwd_a_sel)
         FWD_EXM: alu_a = exmem_q.alu_result;
         FWD_WB:  alu_a = wb_data;
         default: alu_a = idex_q.rs1_data;
      endcase
      unique case (fwd_b_sel)
         FWD_EXM: fwd_b = exmem_q.alu_result;
         FWD_WB:  fwd_b = wb_data;
         default: fwd_b = idex_q.rs2_data;
      endcase
      alu_b = idex_q.ctrl.alu_src ? idex_q.imm : fwd_b;
   end

   always_comb begin
      alu_ctl = ALU_ADD;
      unique case (idex_q.ctrl.alu_op)
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_I: if (idex_q.funct3 == F3_SRA) alu_ctl = ALU_SRA;
         ALUOP_R: begin
            if (idex_q.funct7 == F7_SUB)      alu_ctl = ALU_SUB;
            else if (idex_q.funct7 == F7_MUL) alu_ctl = ALU_MUL;
            else begin
               unique case (idex_q.funct3)
                  F3_AND:  alu_ctl = ALU_AND;
                  F3_XOR:  alu_ctl = ALU_XOR;
                  F3_SLL:  alu_ctl = ALU_SLL;
                  default: alu_ctl = ALU_ADD;
               endcase
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      unique case (alu_ctl)
         ALU_SUB: alu_y = alu_a - alu_b;
         ALU_AND: alu_y = alu_a & alu_b;
         ALU_XOR: alu_y = alu_a ^ alu_b;
         ALU_SLL: alu_y = alu_a << alu_b[4:0];
         ALU_MUL: alu_y = alu_a * alu_b;
         ALU_SRA: alu_y = $signed(alu_a) >>> alu_b[4:0];
         default: alu_y = alu_a + alu_b;
      endcase
   end

   always_comb begin
      exmem_d.reg_write  = idex_q.ctrl.reg_write;
      exmem_d.mem_write  = idex_q.ctrl.mem_write;
      exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
      exmem_d.alu_result = alu_y;
      exmem_d.store_data = fwd_b;
      exmem_d.rd         = idex_q.rd;
   end

   cpu_pipe_reg #(.W($bits(ex_mem_t))) EXMEM (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (1'b1),
      .flush_i (1'b0),
      .d_i     (exmem_d),
      .q_o     (exmem_q)
   );

   // MEM
   cpu_dmem Data_Memory (
      .clk_i   (clk_i),
      .we_i    (exmem_q.mem_write),
      .addr_i  (exmem_q.alu_result[6:2]),
      .wdata_i (exmem_q.store_data),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      memwb_d.mem_data   = mem_rdata;
      memwb_d.alu_result = exmem_q.alu_result;
      memwb_d.rd         = exmem_q.rd;
   end

   cpu_pipe_reg #(.W($bits(mem_wb_t))) MEMWB (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (1'b1),
      .flush_i (1'b0),
      .d_i     (memwb_d),
      .q_o     (memwb_q)
   );

   // WB
   assign wb_data = memwb_q.mem_to_reg ? memwb_q.mem_data
                                       : memwb_q.alu_result;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: expected register writes are queued per
// program and popped as the writeback port fires.
module tb_cpu;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_stall = 0;
   int n_flush = 0;
   logic [36:0] exp_q[$];

   cpu dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7,
      input logic [4:0] rs2, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm,
      input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off,
      input logic [4:0] rs2, input logic [4:0] rs1);
      return {off[12], off[10:5], rs2, rs1, 3'b000,
              off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd,
      input logic [4:0] rs1, input logic [11:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   // Writeback scoreboard plus stall / taken-branch counters.
   always @(negedge clk) begin
      if (!rst) begin
         if (dut.stall) n_stall++;
         if (dut.Control.Branch_o && !dut.stall) n_flush++;
         if (dut.Registers.we_i && dut.Registers.rd_i != 5'd0) begin
            check("wb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
               check("wb", {27'd0, dut.Registers.rd_i,
                            dut.Registers.wdata_i},
                     {27'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic boot();
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 256; i++)
         dut.Instruction_Memory.memory[i] = '0;
      for (int i = 0; i < 32; i++) begin
         dut.Registers.register[i] = '0;
         dut.Data_Memory.memory[i] = '0;
      end
      exp_q.delete();
      n_stall = 0;
      n_flush = 0;
   endtask

   task automatic put(input int a, input logic [31:0] w);
      dut.Instruction_Memory.memory[a] = w;
   endtask

   task automatic expect_wb(input logic [4:0] rd, input logic [31:0] v);
      exp_q.push_back({rd, v});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go();
      cycles(1);
      rst = 1'b0;
      start = 1'b1;
   endtask

   task automatic pipes_zero(input string tag);
      check({tag, "_pc"}, 64'(dut.PC.pc_o), 64'd0);
      check({tag, "_ifid"}, 64'(|dut.IFID.q_o), 64'd0);
      check({tag, "_idex"}, 64'(|dut.IDEX.q_o), 64'd0);
      check({tag, "_exmem"}, 64'(|dut.EXMEM.q_o), 64'd0);
      check({tag, "_memwb"}, 64'(|dut.MEMWB.q_o), 64'd0);
   endtask

   initial begin
      #2;
      pipes_zero("reset");

      // load-use: one stall, forwarded from MEM/WB
      boot();
      dut.Data_Memory.memory[0] = 32'd5;
      put(0, enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011));
      put(1, enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2));
      expect_wb(5'd1, 32'd5);
      expect_wb(5'd2, 32'd10);
      go();
      cycles(12);
      check("t1_drain", 64'(exp_q.size()), 64'd0);
      check("t1_stalls", 64'(n_stall), 64'd1);
      check("t1_x2", 64'(dut.Registers.register[2]), 64'd10);

      // back-to-back EX/MEM and MEM/WB forwarding
      boot();
      put(0, addi(5'd1, 5'd0, 12'd3));
      put(1, addi(5'd2, 5'd1, 12'd4));
      put(2, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3));
      expect_wb(5'd1, 32'd3);
      expect_wb(5'd2, 32'd7);
      expect_wb(5'd3, 32'd4);
      go();
      cycles(12);
      check("t2_drain", 64'(exp_q.size()), 64'd0);
      check("t2_stalls", 64'(n_stall), 64'd0);

      // store, mul, srai, load-back
      boot();
      dut.Registers.register[1] = 32'd5;
      dut.Registers.register[2] = 32'd7;
      put(0, enc_s(12'd4, 5'd2, 5'd0));
      put(1, enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd4));
      put(2, addi(5'd6, 5'd0, 12'hFF8));
      put(3, enc_i(12'h402, 5'd6, 3'b101, 5'd7, 7'b0010011));
      put(4, enc_i(12'd4, 5'd0, 3'b010, 5'd8, 7'b0000011));
      put(5, enc_r(7'b0000000, 5'd6, 5'd7, 3'b111, 5'd9));
      put(6, enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd10));
      put(7, enc_r(7'b0000000, 5'd1, 5'd2, 3'b001, 5'd11));
      put(8, enc_r(7'b1111111, 5'd1, 5'd2, 3'b000, 5'd12));
      expect_wb(5'd4, 32'd35);
      expect_wb(5'd6, 32'hFFFF_FFF8);
      expect_wb(5'd7, 32'hFFFF_FFFE);
      expect_wb(5'd8, 32'd7);
      expect_wb(5'd9, 32'hFFFF_FFF8);
      expect_wb(5'd10, 32'd2);
      expect_wb(5'd11, 32'd224);
      go();
      cycles(16);
      check("t3_drain", 64'(exp_q.size()), 64'd0);
      check("t3_dmem1", 64'(dut.Data_Memory.memory[1]), 64'd7);
      check("t3_x12", 64'(dut.Registers.register[12]), 64'd0);
      check("t3_stalls", 64'(n_stall), 64'd0);

      // beq taken: skip to +12, the fetched slot is flushed
      boot();
      put(0, enc_b(13'd12, 5'd1, 5'd1));
      put(1, addi(5'd5, 5'd0, 12'd9));
      put(2, addi(5'd5, 5'd0, 12'd9));
      put(3, addi(5'd6, 5'd0, 12'd1));
      expect_wb(5'd6, 32'd1);
      go();
      cycles(1);
      check("t4_branch_o", 64'(dut.Control.Branch_o), 64'd1);
      cycles(1);
      check("t4_pc", 64'(dut.PC.pc_o), 64'd12);
      cycles(10);
      check("t4_drain", 64'(exp_q.size()), 64'd0);
      check("t4_x5", 64'(dut.Registers.register[5]), 64'd0);
      check("t4_flush", 64'(n_flush), 64'd1);

      // beq not taken: sequential fetch, no flush
      boot();
      dut.Registers.register[1] = 32'd5;
      dut.Registers.register[2] = 32'd7;
      put(0, enc_b(13'd12, 5'd2, 5'd1));
      put(1, addi(5'd5, 5'd0, 12'd9));
      put(2, addi(5'd6, 5'd0, 12'd1));
      expect_wb(5'd5, 32'd9);
      expect_wb(5'd6, 32'd1);
      go();
      cycles(1);
      check("t5_branch_o", 64'(dut.Control.Branch_o), 64'd0);
      cycles(1);
      check("t5_pc", 64'(dut.PC.pc_o), 64'd8);
      cycles(10);
      check("t5_drain", 64'(exp_q.size()), 64'd0);
      check("t5_flush", 64'(n_flush), 64'd0);

      // mid-program reset, start low hold, then re-execution
      boot();
      put(0, addi(5'd1, 5'd0, 12'd3));
      put(1, addi(5'd2, 5'd1, 12'd4));
      put(2, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3));
      expect_wb(5'd1, 32'd3);
      expect_wb(5'd2, 32'd7);
      expect_wb(5'd3, 32'd4);
      go();
      cycles(2);
      check("t6_pc_run", 64'(dut.PC.pc_o), 64'd8);
      rst = 1'b1;
      start = 1'b0;
      #1;
      pipes_zero("t6_rst");
      rst = 1'b0;
      cycles(3);
      check("t6_pc_hold", 64'(dut.PC.pc_o), 64'd0);
      start = 1'b1;
      cycles(12);
      check("t6_drain", 64'(exp_q.size()), 64'd0);
      check("t6_x3", 64'(dut.Registers.register[3]), 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
